// File: rtl/temp_monitor_pkg.sv
// Shared definitions for the temperature monitor: register map, FSM encoding
// and threshold reset values.
package temp_monitor_pkg;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_PERIOD = 4'd1;
  localparam logic [3:0] REG_HI_TH  = 4'd2;
  localparam logic [3:0] REG_LO_TH  = 4'd3;
  localparam logic [3:0] REG_LAST   = 4'd4;
  localparam logic [3:0] REG_MINMAX = 4'd5;
  localparam logic [3:0] REG_AVG    = 4'd6;
  localparam logic [3:0] REG_STATUS = 4'd7;

  localparam logic [7:0] HI_TH_RST = 8'd160;
  localparam logic [7:0] LO_TH_RST = 8'd150;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

endpackage

// File: rtl/temp_monitor_stats.sv
// Sample statistics: last value, min/max window, exponential average and
// over-temperature alarm with hysteresis, all advanced by a one-cycle strobe.
module temp_stats #(
  parameter int AVG_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       update,
  input  logic       minmax_clr,
  input  logic [7:0] sample,
  input  logic [7:0] hi_th,
  input  logic [7:0] lo_th,
  output logic [7:0] last,
  output logic [7:0] min_v,
  output logic [7:0] max_v,
  output logic [7:0] avg,
  output logic       alarm,
  output logic       valid
);

  logic signed [9:0] diff;
  logic signed [9:0] step;
  logic [7:0]        avg_next;

  // The new average always lies between the old average and the sample,
  // so dropping the top two bits never loses information.
  always_comb begin
    diff     = $signed({2'b00, sample}) - $signed({2'b00, avg});
    step     = diff >>> AVG_SHIFT;
    avg_next = 8'(step + $signed({2'b00, avg}));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last  <= 8'h00;
      min_v <= 8'hFF;
      max_v <= 8'h00;
      avg   <= 8'h00;
      alarm <= 1'b0;
      valid <= 1'b0;
    end else begin
      if (update) begin
        last  <= sample;
        valid <= 1'b1;
        avg   <= valid ? avg_next : sample;
        // Set is tested first so it wins when the thresholds overlap.
        if (sample >= hi_th)      alarm <= 1'b1;
        else if (sample <= lo_th) alarm <= 1'b0;
      end
      if (minmax_clr) begin
        min_v <= 8'hFF;
        max_v <= 8'h00;
      end else if (update) begin
        if (sample < min_v) min_v <= sample;
        if (sample > max_v) max_v <= sample;
      end
    end
  end

endmodule

// File: rtl/temp_monitor.sv
// Periodic LM75 poller: requests transactions from the i2c master, captures the
// reading on the ready edge and exposes statistics/alarm as RIB registers.
module temp_monitor
  import temp_monitor_pkg::*;
#(
  parameter logic [31:0] PERIOD_RST     = 32'd50_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535,
  parameter int          AVG_SHIFT      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        req_i,
  output logic        i2c_req_o,
  input  logic [31:0] i2c_data_i,
  input  logic        i2c_ready_i,
  output logic        irq_o
);

  state_t      state, state_next;
  logic [3:0]  reg_idx;
  logic        wr_ctrl, wr_period, wr_hi, wr_lo, wr_minmax, wr_status;
  logic        enable, irq_en, oneshot;
  logic [31:0] period, period_eff, timer, to_cnt;
  logic [7:0]  hi_th, lo_th, sample_q;
  logic        pending, ready_q, ready_rise, tick, trigger;
  logic        consume, capture, set_terr, timeout_err, busy;
  logic [7:0]  last, min_v, max_v, avg;
  logic        alarm, valid;
  logic        unused_bits;

  assign unused_bits = ^{req_i, addr_i[31:6], addr_i[1:0], i2c_data_i[31:8]};

  assign reg_idx   = addr_i[5:2];
  assign wr_ctrl   = we_i && (reg_idx == REG_CTRL);
  assign wr_period = we_i && (reg_idx == REG_PERIOD);
  assign wr_hi     = we_i && (reg_idx == REG_HI_TH);
  assign wr_lo     = we_i && (reg_idx == REG_LO_TH);
  assign wr_minmax = we_i && (reg_idx == REG_MINMAX);
  assign wr_status = we_i && (reg_idx == REG_STATUS);

  assign ready_rise = i2c_ready_i && !ready_q;
  assign period_eff = (period < 32'd2) ? 32'd2 : period;
  assign tick       = enable && (timer == period_eff - 32'd1);
  assign trigger    = tick || (wr_ctrl && data_i[2]);
  assign busy       = (state != ST_IDLE);
  assign i2c_req_o  = (state == ST_REQ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    consume    = 1'b0;
    capture    = 1'b0;
    set_terr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          consume    = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: state_next = ST_WAIT;
      ST_WAIT: begin
        if (ready_rise) begin
          capture    = 1'b1;
          state_next = ST_UPDATE;
        end else if (to_cnt == TIMEOUT_CYCLES) begin
          set_terr   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_UPDATE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Registers, timer, single-slot pending request and transaction bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      oneshot     <= 1'b0;
      period      <= PERIOD_RST;
      hi_th       <= HI_TH_RST;
      lo_th       <= LO_TH_RST;
      timer       <= 32'd0;
      pending     <= 1'b0;
      ready_q     <= 1'b0;
      to_cnt      <= 32'd0;
      sample_q    <= 8'h00;
      timeout_err <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable  <= data_i[0];
        irq_en  <= data_i[1];
        oneshot <= data_i[2];
      end else begin
        oneshot <= 1'b0;
      end
      if (wr_period) period <= data_i;
      if (wr_hi)     hi_th  <= data_i[7:0];
      if (wr_lo)     lo_th  <= data_i[7:0];

      if (!enable || tick) timer <= 32'd0;
      else                 timer <= timer + 32'd1;

      if (trigger)      pending <= 1'b1;
      else if (consume) pending <= 1'b0;

      ready_q <= i2c_ready_i;

      if (state == ST_REQ)       to_cnt <= 32'd0;
      else if (state == ST_WAIT) to_cnt <= to_cnt + 32'd1;

      if (capture) sample_q <= i2c_data_i[7:0];

      if (set_terr)                    timeout_err <= 1'b1;
      else if (wr_status && data_i[1]) timeout_err <= 1'b0;

      irq_o <= irq_en && (alarm || timeout_err);
    end
  end

  temp_stats #(
    .AVG_SHIFT (AVG_SHIFT)
  ) u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .update     (state == ST_UPDATE),
    .minmax_clr (wr_minmax),
    .sample     (sample_q),
    .hi_th      (hi_th),
    .lo_th      (lo_th),
    .last       (last),
    .min_v      (min_v),
    .max_v      (max_v),
    .avg        (avg),
    .alarm      (alarm),
    .valid      (valid)
  );

  always_comb begin
    data_o = 32'd0;
    case (reg_idx)
      REG_CTRL:   data_o = {29'd0, oneshot, irq_en, enable};
      REG_PERIOD: data_o = period;
      REG_HI_TH:  data_o = {24'd0, hi_th};
      REG_LO_TH:  data_o = {24'd0, lo_th};
      REG_LAST:   data_o = {24'd0, last};
      REG_MINMAX: data_o = {16'd0, max_v, min_v};
      REG_AVG:    data_o = {24'd0, avg};
      REG_STATUS: data_o = {28'd0, valid, busy, timeout_err, alarm};
      default:    data_o = 32'd0;
    endcase
  end

endmodule
